// File: rtl/vec_regfile_pkg.sv
// Shared vector datapath widths and types for the register file and the ALU.
package vec_pkg;
  localparam int LANES   = 16;
  localparam int LANE_W  = 16;
  localparam int FLAG_W  = 4;
  localparam int VEC_W   = LANES * LANE_W;
  localparam int FLAGS_W = LANES * FLAG_W;

  typedef logic [VEC_W-1:0]   vec_t;
  typedef logic [LANE_W-1:0]  lane_t;
  typedef logic [FLAGS_W-1:0] vflags_t;

  // Lane i of a vector, lane 0 in the low bits.
  function automatic lane_t get_lane(vec_t v, int i);
    return v[i*LANE_W +: LANE_W];
  endfunction
endpackage

// File: rtl/vec_regfile_if.sv
// Register-file bus: two read ports, one write port, flag load and busy hint.
interface vec_regfile_if
  import vec_pkg::*;
#(
  parameter int NUM_REGS = 8
);
  localparam int AW = $clog2(NUM_REGS);

  logic [AW-1:0] ra_a;
  logic [AW-1:0] ra_b;
  vec_t          rd_a;
  vec_t          rd_b;
  logic          we;
  logic [AW-1:0] wa;
  vec_t          wd;
  logic          wr_scalar;
  logic          flags_we;
  vflags_t       flags_in;
  vflags_t       flags_out;
  logic          busy_wr;

  // ALU / issue side
  modport master (
    output ra_a, ra_b, we, wa, wd, wr_scalar, flags_we, flags_in,
    input  rd_a, rd_b, flags_out, busy_wr
  );

  // Register file side
  modport slave (
    input  ra_a, ra_b, we, wa, wd, wr_scalar, flags_we, flags_in,
    output rd_a, rd_b, flags_out, busy_wr
  );
endinterface

// File: rtl/vec_wr_merge.sv
// Post-write vector value: lane 0 always from wd, upper lanes from wd
// unless this is a scalar write, in which case they keep the old value.
module vec_wr_merge
  import vec_pkg::*;
(
  input  vec_t old_v,
  input  vec_t wd,
  input  logic wr_scalar,
  output vec_t merged
);
  assign merged[LANE_W-1:0] = wd[LANE_W-1:0];

  for (genvar i = 1; i < LANES; i++) begin : g_lane
    assign merged[i*LANE_W +: LANE_W] = wr_scalar ? old_v[i*LANE_W +: LANE_W]
                                                  : wd[i*LANE_W +: LANE_W];
  end
endmodule

// File: rtl/vec_regfile.sv
// Vector register file feeding the 16-lane ALU: two combinational read ports
// with same-cycle write bypass, one full/scalar write port, flag register.
module vec_regfile
  import vec_pkg::*;
#(
  parameter int NUM_REGS = 8
)(
  input  logic          clk,
  input  logic          rst,
  vec_regfile_if.slave  bus
);
  vec_t regs [NUM_REGS];
  vec_t wr_merged;
  vec_t byp_a;
  vec_t byp_b;
  logic wr_en;

  // Reset overrides the write port, including the bypass paths, so reads
  // show the cleared storage while rst is high.
  assign wr_en = bus.we & ~rst;

  // One merge for storage and one per bypass port; all see the same inputs,
  // so the forwarded value always equals what gets stored.
  vec_wr_merge u_wr_merge (
    .old_v(regs[bus.wa]), .wd(bus.wd), .wr_scalar(bus.wr_scalar), .merged(wr_merged)
  );
  vec_wr_merge u_byp_a (
    .old_v(regs[bus.wa]), .wd(bus.wd), .wr_scalar(bus.wr_scalar), .merged(byp_a)
  );
  vec_wr_merge u_byp_b (
    .old_v(regs[bus.wa]), .wd(bus.wd), .wr_scalar(bus.wr_scalar), .merged(byp_b)
  );

  // Zero-latency reads, forwarding the in-flight write on address match.
  assign bus.rd_a = (wr_en && (bus.wa == bus.ra_a)) ? byp_a : regs[bus.ra_a];
  assign bus.rd_b = (wr_en && (bus.wa == bus.ra_b)) ? byp_b : regs[bus.ra_b];

  // Register storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (bus.we) begin
      regs[bus.wa] <= wr_merged;
    end
  end

  // Flag register and write-committed hint.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.flags_out <= '0;
      bus.busy_wr   <= 1'b0;
    end else begin
      if (bus.flags_we) bus.flags_out <= bus.flags_in;
      bus.busy_wr <= bus.we;
    end
  end
endmodule

// File: tb/tb_vec_regfile.sv
// Randomised and directed bench for vec_regfile against a behavioural model.
module tb_vec_regfile;
  import vec_pkg::*;

  localparam int NR = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vec_regfile_if #(.NUM_REGS(NR)) bus ();

  vec_regfile #(.NUM_REGS(NR)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  vec_t    m_regs [NR];
  vflags_t m_flags;
  logic    m_busy;

  function automatic vec_t bcast(lane_t v);
    return {LANES{v}};
  endfunction

  function automatic vec_t m_merge(vec_t old_v, vec_t d, logic sc);
    vec_t r;
    r = sc ? old_v : d;
    r[15:0] = d[15:0];
    return r;
  endfunction

  // Expected read: stored value, or in-flight write when addresses match.
  function automatic vec_t m_rd(logic [2:0] ra, logic r, logic w, logic [2:0] a,
                                vec_t d, logic sc);
    if (!r && w && a == ra) return m_merge(m_regs[a], d, sc);
    return m_regs[ra];
  endfunction

  function automatic vec_t exp_a();
    return m_rd(bus.ra_a, rst, bus.we, bus.wa, bus.wd, bus.wr_scalar);
  endfunction

  function automatic vec_t exp_b();
    return m_rd(bus.ra_b, rst, bus.we, bus.wa, bus.wd, bus.wr_scalar);
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < VEC_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < NR; r++) m_regs[r] = '0;
    m_flags = '0;
    m_busy  = 1'b0;
  endtask

  // Advance one edge, update the model from the inputs in force at it.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_clear();
    end else begin
      if (bus.we) m_regs[bus.wa] = m_merge(m_regs[bus.wa], bus.wd, bus.wr_scalar);
      if (bus.flags_we) m_flags = bus.flags_in;
      m_busy = bus.we;
    end
    #1;
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.wa = '0; bus.wd = '0; bus.wr_scalar = 1'b0;
    bus.flags_we = 1'b0; bus.flags_in = '0;
  endtask

  task automatic test_reset();
    vec_t d7;
    idle();
    bus.ra_a = 3'd0; bus.ra_b = 3'd5;
    m_clear();
    tick(); tick();
    n_checks++;
    if (bus.rd_a !== '0 || bus.rd_b !== '0) begin
      n_fail++; $display("FAIL reset_rd: got %h / %h required 0", bus.rd_a, bus.rd_b);
    end
    n_checks++;
    if (bus.flags_out !== '0 || bus.busy_wr !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags_busy: got %h %b required 0 0", bus.flags_out, bus.busy_wr);
    end
    // write presented as reset releases commits at that edge
    d7 = rand_vec();
    rst = 1'b0; bus.we = 1'b1; bus.wa = 3'd7; bus.wd = d7;
    tick();
    idle(); bus.ra_a = 3'd7;
    #1;
    n_checks++;
    if (bus.rd_a !== d7) begin
      n_fail++; $display("FAIL reset_release_write: got %h required %h", bus.rd_a, d7);
    end
    // broadcast 0x1234 everywhere, load some flags
    for (int r = 0; r < NR; r++) begin
      bus.we = 1'b1; bus.wa = r[2:0]; bus.wd = bcast(16'h1234);
      bus.flags_we = 1'b1; bus.flags_in = 64'hDEAD_BEEF_0123_4567;
      tick();
    end
    // start another write, then hit reset mid-cycle
    bus.flags_we = 1'b0; bus.we = 1'b1; bus.wa = 3'd0; bus.wd = rand_vec();
    bus.ra_a = 3'd3; bus.ra_b = 3'd6;
    #1;
    n_checks++;
    if (bus.rd_a !== bcast(16'h1234) || bus.busy_wr !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_state: got %h busy %b", bus.rd_a, bus.busy_wr);
    end
    #1 rst = 1'b1;
    m_clear();
    #1;
    n_checks++;
    if (bus.rd_a !== '0 || bus.rd_b !== '0) begin
      n_fail++; $display("FAIL async_reset_rd: got %h / %h required 0", bus.rd_a, bus.rd_b);
    end
    n_checks++;
    if (bus.flags_out !== '0 || bus.busy_wr !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_flags_busy: got %h %b required 0 0", bus.flags_out, bus.busy_wr);
    end
    // we held high through reset edges: nothing lands
    tick(); tick();
    rst = 1'b0; idle(); bus.ra_a = 3'd0; bus.ra_b = 3'd3;
    #1;
    n_checks++;
    if (bus.rd_a !== '0 || bus.rd_b !== '0 || bus.busy_wr !== 1'b0) begin
      n_fail++; $display("FAIL reset_blocks_we: got %h / %h busy %b required 0", bus.rd_a, bus.rd_b, bus.busy_wr);
    end
  endtask

  task automatic test_full_write();
    vec_t d;
    for (int i = 0; i < LANES; i++) d[i*16 +: 16] = 16'h0100 + 16'(i);
    bus.we = 1'b1; bus.wa = 3'd3; bus.wd = d; bus.wr_scalar = 1'b0; bus.ra_a = 3'd0;
    tick();
    idle(); bus.ra_a = 3'd3;
    #1;
    n_checks++;
    if (get_lane(bus.rd_a, 5) !== 16'h0105 || get_lane(bus.rd_a, 15) !== 16'h010F) begin
      n_fail++; $display("FAIL full_write_lanes: got %h %h required 0105 010f",
                         get_lane(bus.rd_a, 5), get_lane(bus.rd_a, 15));
    end
    n_checks++;
    if (bus.busy_wr !== 1'b1) begin
      n_fail++; $display("FAIL busy_set: got %b required 1", bus.busy_wr);
    end
    tick();
    n_checks++;
    if (bus.busy_wr !== 1'b0) begin
      n_fail++; $display("FAIL busy_clear: got %b required 0", bus.busy_wr);
    end
  endtask

  task automatic test_scalar_write();
    vec_t e;
    bus.we = 1'b1; bus.wa = 3'd2; bus.wd = bcast(16'hAAAA); bus.wr_scalar = 1'b0;
    tick();
    bus.wd = bcast(16'h5555); bus.wr_scalar = 1'b1;
    tick();
    idle(); bus.ra_a = 3'd2;
    #1;
    e = bcast(16'hAAAA); e[15:0] = 16'h5555;
    n_checks++;
    if (bus.rd_a !== e) begin
      n_fail++; $display("FAIL scalar_write: got %h required %h", bus.rd_a, e);
    end
  endtask

  task automatic test_bypass();
    vec_t e;
    bus.we = 1'b1; bus.wa = 3'd4; bus.wd = '0; bus.wr_scalar = 1'b0;
    tick();
    bus.wd = bcast(16'hFFFF); bus.ra_a = 3'd4; bus.ra_b = 3'd4;
    #1;
    n_checks++;
    if (bus.rd_a !== bcast(16'hFFFF) || bus.rd_b !== bcast(16'hFFFF)) begin
      n_fail++; $display("FAIL bypass_full: got %h / %h required all ffff", bus.rd_a, bus.rd_b);
    end
    bus.wr_scalar = 1'b1;
    #1;
    e = '0; e[15:0] = 16'hFFFF;
    n_checks++;
    if (bus.rd_a !== e || bus.rd_b !== e) begin
      n_fail++; $display("FAIL bypass_scalar: got %h / %h required %h", bus.rd_a, bus.rd_b, e);
    end
    bus.ra_b = 3'd5;
    #1;
    n_checks++;
    if (bus.rd_b !== m_regs[5] || bus.rd_a !== e) begin
      n_fail++; $display("FAIL bypass_other_port: got %h required %h", bus.rd_b, m_regs[5]);
    end
    tick();
    idle();
  endtask

  task automatic test_flags();
    bus.flags_we = 1'b1; bus.flags_in = 64'h8421_0000_0000_000F;
    tick();
    n_checks++;
    if (bus.flags_out !== 64'h8421_0000_0000_000F) begin
      n_fail++; $display("FAIL flags_load: got %h required 8421_0000_0000_000f", bus.flags_out);
    end
    bus.flags_we = 1'b0; bus.flags_in = '0;
    tick();
    n_checks++;
    if (bus.flags_out !== 64'h8421_0000_0000_000F) begin
      n_fail++; $display("FAIL flags_hold: got %h required 8421_0000_0000_000f", bus.flags_out);
    end
    bus.flags_we = 1'b1; bus.flags_in = 64'h0123_4567_89AB_CDEF; bus.we = 1'b0;
    bus.wd = rand_vec(); bus.wa = 3'd1;
    tick();
    idle();
    n_checks++;
    if (bus.flags_out !== 64'h0123_4567_89AB_CDEF) begin
      n_fail++; $display("FAIL flags_reload: got %h required 0123_4567_89ab_cdef", bus.flags_out);
    end
    for (int r = 0; r < NR; r++) begin
      bus.ra_a = r[2:0];
      #1;
      n_checks++;
      if (bus.rd_a !== m_regs[r]) begin
        n_fail++; $display("FAIL flags_no_reg_change r%0d: got %h required %h", r, bus.rd_a, m_regs[r]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bus.we = 1'b1; bus.wa = 3'd1; bus.wd = bcast(16'h0001); bus.wr_scalar = 1'b0;
    tick();
    bus.wd = bcast(16'h0002); bus.ra_a = 3'd1;
    #1;
    n_checks++;
    if (bus.rd_a !== bcast(16'h0002)) begin
      n_fail++; $display("FAIL b2b_bypass: got %h required all 0002", bus.rd_a);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (bus.rd_a !== bcast(16'h0002)) begin
      n_fail++; $display("FAIL b2b_storage: got %h required all 0002", bus.rd_a);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      bus.we        = ($urandom_range(0, 3) != 0);
      bus.wa        = 3'($urandom_range(0, NR-1));
      bus.wd        = rand_vec();
      bus.wr_scalar = ($urandom_range(0, 2) == 0);
      bus.flags_we  = $urandom_range(0, 1) == 1;
      bus.flags_in  = {$urandom, $urandom};
      bus.ra_a      = ($urandom_range(0, 2) == 0) ? bus.wa : 3'($urandom_range(0, NR-1));
      bus.ra_b      = ($urandom_range(0, 2) == 0) ? bus.wa : 3'($urandom_range(0, NR-1));
      #2;
      n_checks++;
      if (bus.rd_a !== exp_a() || bus.rd_b !== exp_b()) begin
        n_fail++; $display("FAIL rand_rd c%0d: got %h / %h required %h / %h",
                           c, bus.rd_a, bus.rd_b, exp_a(), exp_b());
      end
      n_checks++;
      if (bus.flags_out !== m_flags || bus.busy_wr !== m_busy) begin
        n_fail++; $display("FAIL rand_state c%0d: got %h %b required %h %b",
                           c, bus.flags_out, bus.busy_wr, m_flags, m_busy);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    bus.ra_a = '0; bus.ra_b = '0;
    test_reset();
    test_full_write();
    test_scalar_write();
    test_bypass();
    test_flags();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vec_regfile.md
Name: vec_regfile

Overview:
- Vector register file directly upstream of the 16-lane vector ALU.
- Supplies the two 256-bit operands (A, B): 16 lanes x 16 bits, lane i at bits [16i+15:16i].
- Accepts the 256-bit write-back result and the 64-bit per-lane flag word (4 flags per lane) at the end of execute.
- Same-cycle write-to-read bypass, so an instruction can consume a result written by the instruction ahead of it.

Parameters:
- NUM_REGS, 8, number of vector registers (power of two, at least 2)
- LANES, 16, lanes per vector
- LANE_W, 16, bits per lane
- FLAG_W, 4, flag bits per lane

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ra_a  in  $clog2(NUM_REGS)  read address, operand A
- ra_b  in  $clog2(NUM_REGS)  read address, operand B
- rd_a  out  LANES*LANE_W  operand A data
- rd_b  out  LANES*LANE_W  operand B data
- we  in  1  vector write enable
- wa  in  $clog2(NUM_REGS)  write address
- wd  in  LANES*LANE_W  write data (ALU result)
- wr_scalar  in  1  scalar write: only lane 0 is updated
- flags_we  in  1  flag register load enable
- flags_in  in  LANES*FLAG_W  flag word from ALU
- flags_out  out  LANES*FLAG_W  registered flag word
- busy_wr  out  1  registered: a write committed in the previous cycle (scoreboard hint)

Behaviour:
- Reset:
  - Asynchronous; rst high immediately clears all NUM_REGS registers, flags_out and busy_wr to 0.
  - rst dominates we and flags_we in every cycle.
  - A write presented in the cycle rst deasserts but before the next rising edge commits at that edge.
- Read: combinational, zero latency. rd_a = reg[ra_a] and rd_b = reg[ra_b], subject to the bypass rules below.
- Write:
  - Commits on the rising edge when we=1.
  - wr_scalar=0: all 16 lanes of reg[wa] take wd.
  - wr_scalar=1: lane 0 (bits 15:0) takes wd[15:0]; lanes 1..15 keep their old value.
- Bypass:
  - If we=1 and wa==ra_a, rd_a returns the post-write merged value in the same cycle.
  - Merged value: full wd when wr_scalar=0; {reg[wa][255:16], wd[15:0]} when wr_scalar=1.
  - The same rule applies independently to rd_b.
  - ra_a==ra_b==wa: both ports return the identical merged value.
  - Bypass is combinational. No extra register stage, no added latency.
- Flags:
  - flags_out loads flags_in on the rising edge when flags_we=1; otherwise it holds.
  - No bypass on flags; the new value is visible the cycle after the edge.
  - we and flags_we are independent; either, both or neither may be asserted.
- busy_wr: flop equal to we sampled at the last edge; reset value 0.
- Address range: all addresses are in range by construction (NUM_REGS is a power of two); there is no wrap or error case.
- Simultaneous write to the same register: impossible (single write port). Back-to-back writes to the same wa: the last edge wins.
- X-free: undriven wd lanes are never merged, because scalar mode takes only wd[15:0].

Decomposition:
- Shared package vec_pkg:
  - LANES, LANE_W, FLAG_W, VEC_W=LANES*LANE_W, FLAGS_W=LANES*FLAG_W
  - typedef vec_t (logic [VEC_W-1:0]), typedef lane_t, typedef vflags_t
  - The same package is imported by the ALU side to keep widths consistent.
- One natural sub-module: vec_wr_merge.
  - Combinational; inputs old vector, wd, wr_scalar; output merged vector.
  - Used once for the storage write and twice for the bypass paths (three instances), so storage and bypass can never disagree.

Test Plan:
- Reset:
  - Write 0x1234 broadcast to all regs.
  - Assert rst asynchronously mid-cycle -> rd_a/rd_b drop to 0 before the next edge; flags_out=0, busy_wr=0.
  - Hold we=1 during rst -> no write occurs.
- Full write then read:
  - we=1, wa=3, wd = lane i value 0x0100+i, wr_scalar=0.
  - Next cycle ra_a=3 -> rd_a lane 5 = 0x0105, lane 15 = 0x010F; busy_wr=1 for one cycle.
- Scalar write:
  - reg2 preloaded with all lanes 0xAAAA.
  - we=1, wa=2, wr_scalar=1, wd = all lanes 0x5555 -> reg2 lane0=0x5555, lanes 1-15 stay 0xAAAA.
- Bypass:
  - reg4 = all 0x0000; same cycle we=1, wa=4, wd = all 0xFFFF, ra_a=4, ra_b=4 -> rd_a=rd_b=all 0xFFFF combinationally.
  - Repeat with wr_scalar=1 -> lane0=0xFFFF, others 0x0000.
  - ra_b=5 -> rd_b unaffected.
- Flags:
  - flags_we=1, flags_in=0x8421_0000_0000_000F -> flags_out equals that value after the edge.
  - Next cycle flags_we=0, flags_in=0 -> flags_out holds.
  - flags_we=1 with we=0 -> no register change.
- Back-to-back writes:
  - Cycle n: wa=1, wd = all 0x0001. Cycle n+1: wa=1, wd = all 0x0002 with ra_a=1.
  - -> rd_a shows 0x0002 via bypass in n+1, and 0x0002 from storage in n+2.
